// File: rtl/excp_ctrl_pkg.sv
// rtl/excp_ctrl_pkg.sv - shared CSR addresses, cause codes, bit indices and FSM encoding for excp_ctrl
package excp_ctrl_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MIE     = 12'h304,
    CSR_MTVEC   = 12'h305,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MTVAL   = 12'h343
  } csr_addr_e;

  typedef enum logic [3:0] {
    CAUSE_ILLEGAL_INSN = 4'd2,
    CAUSE_BREAKPOINT   = 4'd3,
    CAUSE_LD_MISALIGN  = 4'd4,
    CAUSE_ST_MISALIGN  = 4'd6,
    CAUSE_ECALL_M      = 4'd11
  } exc_code_e;

  typedef enum logic [3:0] {
    CAUSE_MSI = 4'd3,
    CAUSE_MTI = 4'd7,
    CAUSE_MEI = 4'd11
  } irq_code_e;

  // mstatus / mie bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MSIE       = 3;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

  // ls_excp_i = {illegal, ecall, ebreak, ld_misalign, st_misalign}
  localparam int EXC_ILLEGAL = 4;
  localparam int EXC_ECALL   = 3;
  localparam int EXC_EBREAK  = 2;
  localparam int EXC_LD_MIS  = 1;
  localparam int EXC_ST_MIS  = 0;

  // irq_i = {meip, mtip, msip}
  localparam int IRQ_MEIP = 2;
  localparam int IRQ_MTIP = 1;
  localparam int IRQ_MSIP = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEPC    = 3'd1,
    ST_MCAUSE  = 3'd2,
    ST_MTVAL   = 3'd3,
    ST_MSTATUS = 3'd4,
    ST_MRET    = 3'd5
  } state_e;

endpackage

// File: rtl/excp_arb.sv
// rtl/excp_arb.sv - fixed-priority selection of the trap to take from ls exceptions and interrupts
module excp_arb
  import excp_ctrl_pkg::*;
#(
  parameter int MCAUSE_W = 4
) (
  input  logic                valid,
  input  logic [4:0]          excp,
  input  logic [2:0]          irq,
  input  logic [2:0]          irq_en,
  input  logic                glb_ie,
  output logic                take,
  output logic                is_irq,
  output logic [MCAUSE_W-1:0] code
);

  logic [2:0] pend;

  // An interrupt is only taken on a live ls instruction, which it then kills.
  assign pend = irq & irq_en & {3{glb_ie & valid}};

  // Exceptions beat interrupts; within each group the architectural order applies.
  always_comb begin
    take   = 1'b0;
    is_irq = 1'b0;
    code   = '0;
    if (valid && excp[EXC_ILLEGAL]) begin
      take = 1'b1;
      code = MCAUSE_W'(CAUSE_ILLEGAL_INSN);
    end else if (valid && excp[EXC_EBREAK]) begin
      take = 1'b1;
      code = MCAUSE_W'(CAUSE_BREAKPOINT);
    end else if (valid && excp[EXC_ECALL]) begin
      take = 1'b1;
      code = MCAUSE_W'(CAUSE_ECALL_M);
    end else if (valid && excp[EXC_LD_MIS]) begin
      take = 1'b1;
      code = MCAUSE_W'(CAUSE_LD_MISALIGN);
    end else if (valid && excp[EXC_ST_MIS]) begin
      take = 1'b1;
      code = MCAUSE_W'(CAUSE_ST_MISALIGN);
    end else if (pend[IRQ_MEIP]) begin
      take   = 1'b1;
      is_irq = 1'b1;
      code   = MCAUSE_W'(CAUSE_MEI);
    end else if (pend[IRQ_MSIP]) begin
      take   = 1'b1;
      is_irq = 1'b1;
      code   = MCAUSE_W'(CAUSE_MSI);
    end else if (pend[IRQ_MTIP]) begin
      take   = 1'b1;
      is_irq = 1'b1;
      code   = MCAUSE_W'(CAUSE_MTI);
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// rtl/excp_ctrl.sv - trap/mret/fence.i sequencer; EXCP_MTVAL_EN adds the mtval write state
module excp_ctrl
  import excp_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MCAUSE_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ls_valid_i,
  input  logic [XLEN-1:0] ls_pc_i,
  input  logic [4:0]      ls_excp_i,
  input  logic [XLEN-1:0] ls_tval_i,
  input  logic            ls_mret_i,
  input  logic            ex_fencei_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [2:0]      irq_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mie_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic            ls_ahb_stallreq_i,
  output logic            excp_stallreq_o,
  output logic [1:0]      excp_flushreq_o,
  output logic            excp_jump_req_o,
  output logic [XLEN-1:0] excp_jump_addr_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o
);

  state_e                state;
  logic                  is_irq_q;
  logic [MCAUSE_W-1:0]   code_q;
  logic                  csr_we_q;
  logic [11:0]           csr_waddr_q;
  logic [XLEN-1:0]       csr_wdata_q;
  logic                  jump_req_q;
  logic [1:0]            flush_q;
  logic [XLEN-1:0]       jump_addr_q;

  logic                  arb_take;
  logic                  arb_is_irq;
  logic [MCAUSE_W-1:0]   arb_code;
  logic                  eval_en;
  logic                  trap_take;
  logic                  mret_take;
  logic                  fencei_take;
  logic                  fencei_out;
  logic [XLEN-1:0]       cause_val;
  logic [XLEN-1:0]       trap_mstatus;
  logic [XLEN-1:0]       mret_mstatus;
  logic [XLEN-1:0]       trap_target;
  logic [XLEN-1:0]       mtvec_base;
  logic                  unused_bits;

`ifdef EXCP_MTVAL_EN
  logic [XLEN-1:0]       tval_q;
  assign unused_bits = ^{csr_mie_i[XLEN-1:12], csr_mie_i[10:8], csr_mie_i[6:4],
                         csr_mie_i[2:0], ls_pc_i[1:0]};
`else
  assign unused_bits = ^{csr_mie_i[XLEN-1:12], csr_mie_i[10:8], csr_mie_i[6:4],
                         csr_mie_i[2:0], ls_pc_i[1:0], ls_tval_i};
`endif

  excp_arb #(
    .MCAUSE_W(MCAUSE_W)
  ) u_arb (
    .valid  (ls_valid_i),
    .excp   (ls_excp_i),
    .irq    (irq_i),
    .irq_en ({csr_mie_i[MIE_MEIE], csr_mie_i[MIE_MTIE], csr_mie_i[MIE_MSIE]}),
    .glb_ie (csr_mstatus_i[MSTATUS_MIE]),
    .take   (arb_take),
    .is_irq (arb_is_irq),
    .code   (arb_code)
  );

  // Events are only looked at when idle and no ls bus transfer is in flight.
  assign eval_en     = (state == ST_IDLE) && !ls_ahb_stallreq_i;
  assign trap_take   = eval_en && arb_take;
  assign mret_take   = eval_en && !arb_take && ls_valid_i && ls_mret_i;
  assign fencei_take = eval_en && !arb_take && !(ls_valid_i && ls_mret_i) && ex_fencei_i;
  assign fencei_out  = fencei_take && !rst;

  // mcause value from the latched trap, interrupt flag in the top bit.
  always_comb begin
    cause_val                = '0;
    cause_val[XLEN-1]        = is_irq_q;
    cause_val[MCAUSE_W-1:0]  = code_q;
  end

  // mstatus images for trap entry and mret, built from the live CSR value.
  always_comb begin
    trap_mstatus                                = csr_mstatus_i;
    trap_mstatus[MSTATUS_MPIE]                  = csr_mstatus_i[MSTATUS_MIE];
    trap_mstatus[MSTATUS_MIE]                   = 1'b0;
    trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mret_mstatus                                = csr_mstatus_i;
    mret_mstatus[MSTATUS_MIE]                   = csr_mstatus_i[MSTATUS_MPIE];
    mret_mstatus[MSTATUS_MPIE]                  = 1'b1;
  end

  // Trap target: vectored mode offsets only interrupts; the add wraps naturally.
  always_comb begin
    mtvec_base  = {csr_mtvec_i[XLEN-1:2], 2'b00};
    trap_target = mtvec_base;
    if (csr_mtvec_i[1:0] == 2'b01 && is_irq_q) begin
      trap_target = mtvec_base + (XLEN'(code_q) << 2);
    end
  end

  // Sequencer: one CSR write per state, pulses registered and cleared every cycle by default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      is_irq_q    <= 1'b0;
      code_q      <= '0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      jump_req_q  <= 1'b0;
      flush_q     <= 2'b00;
      jump_addr_q <= '0;
`ifdef EXCP_MTVAL_EN
      tval_q      <= '0;
`endif
    end else begin
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      jump_req_q  <= 1'b0;
      flush_q     <= 2'b00;
      jump_addr_q <= '0;
      case (state)
        ST_IDLE: begin
          if (trap_take) begin
            state       <= ST_MEPC;
            is_irq_q    <= arb_is_irq;
            code_q      <= arb_code;
`ifdef EXCP_MTVAL_EN
            tval_q      <= arb_is_irq ? '0 : ls_tval_i;
`endif
            csr_we_q    <= 1'b1;
            csr_waddr_q <= CSR_MEPC;
            csr_wdata_q <= {ls_pc_i[XLEN-1:2], 2'b00};
          end else if (mret_take) begin
            state       <= ST_MRET;
            csr_we_q    <= 1'b1;
            csr_waddr_q <= CSR_MSTATUS;
            csr_wdata_q <= mret_mstatus;
            jump_req_q  <= 1'b1;
            flush_q     <= 2'b10;
            jump_addr_q <= csr_mepc_i;
          end
        end
        ST_MEPC: begin
          state       <= ST_MCAUSE;
          csr_we_q    <= 1'b1;
          csr_waddr_q <= CSR_MCAUSE;
          csr_wdata_q <= cause_val;
        end
        ST_MCAUSE: begin
`ifdef EXCP_MTVAL_EN
          state       <= ST_MTVAL;
          csr_we_q    <= 1'b1;
          csr_waddr_q <= CSR_MTVAL;
          csr_wdata_q <= tval_q;
`else
          state       <= ST_MSTATUS;
          csr_we_q    <= 1'b1;
          csr_waddr_q <= CSR_MSTATUS;
          csr_wdata_q <= trap_mstatus;
          jump_req_q  <= 1'b1;
          flush_q     <= 2'b10;
          jump_addr_q <= trap_target;
`endif
        end
`ifdef EXCP_MTVAL_EN
        ST_MTVAL: begin
          state       <= ST_MSTATUS;
          csr_we_q    <= 1'b1;
          csr_waddr_q <= CSR_MSTATUS;
          csr_wdata_q <= trap_mstatus;
          jump_req_q  <= 1'b1;
          flush_q     <= 2'b10;
          jump_addr_q <= trap_target;
        end
`endif
        ST_MSTATUS: state <= ST_IDLE;
        ST_MRET:    state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Stall covers the detect cycle and the CSR states before the redirect; fence.i redirects in place.
  assign excp_stallreq_o  = ((trap_take || mret_take) && !rst) ||
                            (state == ST_MEPC) || (state == ST_MCAUSE) || (state == ST_MTVAL);
  assign excp_jump_req_o  = jump_req_q || fencei_out;
  assign excp_flushreq_o  = fencei_out ? 2'b01 : flush_q;
  assign excp_jump_addr_o = fencei_out ? (ex_pc_i + XLEN'(4)) : jump_addr_q;
  assign csr_we_o         = csr_we_q;
  assign csr_waddr_o      = csr_waddr_q;
  assign csr_wdata_o      = csr_wdata_q;

endmodule
